sha1_msg_padder: RTL and testbench
==================================

// Module: sha1_msg_padder
// PURPOSE
//  Upstream message front-end for the SHA-1 engine (sha1_dfa).
//  - Accepts a byte-aligned message as a valid/ready stream of 32-bit big-endian words.
//  - Emits complete 512-bit blocks as 16-word streams: data words, then the 0x80 pad byte,
//    then zero fill, then the 64-bit big-endian bit length.
//  - One output word per accepted handshake; the engine never sees a partial block.
// PARAMETERS
//  BCNT_W   32   width of the internal message byte counter; counter wraps modulo 2^BCNT_W
// PORTS
//  clk           in   1   single clock; all logic on posedge clk
//  rst           in   1   asynchronous active-low reset (0 = reset)
//  data_i        in   32  message word, first byte in [31:24]
//  valid_i       in   1   data_i/last_i/last_bytes_i valid
//  last_i        in   1   data_i is the final word of the message
//  last_bytes_i  in   3   valid bytes in the final word, 0..4, left-aligned; ignored when last_i=0
//  ready_o       out  1   padder accepts data_i this cycle (valid_i & ready_o = transfer)
//  word_o        out  32  block word toward sha1_dfa
//  word_valid_o  out  1   word_o valid
//  word_ready_i  in   1   consumer takes word_o (word_valid_o & word_ready_i = transfer)
//  block_last_o  out  1   word_o is word 15 of a block
//  msg_last_o    out  1   word_o is word 15 of the final block of the message
//  busy_o        out  1   a message is in progress (first word accepted, final word not yet emitted)
// BEHAVIOUR
//  Reset
//   - All outputs are 0; state = PASS; word index widx = 0; byte counter bcnt = 0; pad_pend = 0.
//   - Reset mid-message discards all state; the next accepted word starts a new message.
//  Output register
//   - Single output register. word_o and the flags hold stable while word_valid_o=1 and
//     word_ready_i=0.
//   - out_free = !word_valid_o | word_ready_i.
//   - Latency from accepted input to word_valid_o is 1 cycle.
//   - widx increments mod 16 on each output transfer.
//  FSM: PASS -> PAD -> LEN_HI -> LEN_LO -> PASS
//   PASS
//    - ready_o = out_free. Each accepted word loads the output register.
//    - last_i=0: word is loaded unchanged; bcnt += 4.
//    - last_i=1, k = last_bytes_i:
//      - k=0..3: bytes [k..3] are replaced by 0x80 followed by zeros; bcnt += k.
//      - k=4: word is loaded unchanged, bcnt += 4, pad_pend = 1.
//      - Then go to PAD.
//    - busy_o is set on the first accepted word.
//   PAD
//    - ready_o = 0.
//    - Load one word per out_free cycle: 0x80000000 if pad_pend (then clear pad_pend), else 0.
//    - Leave for LEN_HI when the next slot to be loaded is index 14 and pad_pend = 0.
//    - If the 0x80 word lands at index 14 or 15, fill zeros to index 15, wrap to 0, and pad
//      a second block.
//   LEN_HI / LEN_LO (ready_o = 0)
//    - Load the upper and lower 32 bits of {bcnt,3'b000}, zero-extended to 64 bits.
//    - LEN_LO word carries block_last_o = msg_last_o = 1.
//    - Its output transfer clears busy_o, bcnt and widx, and returns to PASS.
//  Flags
//   - block_last_o = 1 for every word loaded at widx 15.
//   - msg_last_o = 1 only for the LEN_LO word.
//  Boundaries
//   - Empty message (last_i with k=0 as the first word): emits 0x80000000, 13 zeros, 0, 0.
//   - A message of 56..63 bytes mod 64 needs two blocks.
//   - valid_i held while ready_o=0: the word is neither lost nor duplicated.
//   - last_bytes_i > 4 is illegal; the bench asserts it is never driven.
// TESTING
//  1. "abc": data_i=0x61626300, last_i=1, k=3 -> 16 words: 0x61626380, 13x0, 0x0, 0x18;
//     block_last_o and msg_last_o on word 16.
//  2. Empty: data_i=0, last_i=1, k=0 -> 0x80000000, 14x0, 0x0 (length 0);
//     msg_last_o on word 16.
//  3. 56 bytes (14 words, last k=4) -> 32 words: 14 data words, 0x80000000, 0,
//     then 14x0, 0x0, 0x1C0. block_last_o on words 16 and 32; msg_last_o on word 32 only.
//  4. 64 bytes of 0x31323334 -> 16 data words (block_last_o on word 16, msg_last_o=0),
//     then 0x80000000, 13x0, 0x0, 0x200.
//  5. Backpressure: random word_ready_i stalls during test 3 -> word_o stable while stalled;
//     identical 32-word sequence; ready_o=0 outside PASS.
//  6. rst pulsed low after 5 words of a message -> all outputs 0 next edge;
//     then running test 1 gives exactly test 1's output.

Source files
------------

// File: rtl/sha1_msg_padder.sv
// SHA-1 message front-end: turns a byte-aligned word stream into padded 512-bit blocks
// (data, 0x80, zero fill, 64-bit big-endian bit length) as 16-word output streams.
module sha1_msg_padder #(
    parameter int BCNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    input  logic        last_i,
    input  logic [2:0]  last_bytes_i,
    output logic        ready_o,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        block_last_o,
    output logic        msg_last_o,
    output logic        busy_o
);

    localparam logic [1:0] S_PASS   = 2'd0;
    localparam logic [1:0] S_PAD    = 2'd1;
    localparam logic [1:0] S_LEN_HI = 2'd2;
    localparam logic [1:0] S_LEN_LO = 2'd3;

    logic [1:0]        state;
    logic [3:0]        widx;
    logic [3:0]        widx_nxt;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_inc;
    logic              pad_pend;
    logic              lo_loaded;
    logic              run;
    logic              out_free;
    logic              accept;
    logic              load;
    logic [31:0]       pad_word;
    logic [31:0]       ld_word;
    logic [63:0]       len_bits;

    // run keeps ready_o low while reset is asserted so every output reads 0.
    assign out_free = !word_valid_o || word_ready_i;
    assign ready_o  = run && (state == S_PASS) && out_free;
    assign accept   = valid_i && ready_o;
    assign widx_nxt = widx + 4'd1;
    assign len_bits = {{(61-BCNT_W){1'b0}}, bcnt, 3'b000};
    assign bcnt_inc = last_i ? BCNT_W'(last_bytes_i) : BCNT_W'(3'd4);

    always_comb begin
        pad_word = data_i;
        case (last_bytes_i)
            3'd0:    pad_word = 32'h8000_0000;
            3'd1:    pad_word = {data_i[31:24], 24'h80_0000};
            3'd2:    pad_word = {data_i[31:16], 16'h8000};
            3'd3:    pad_word = {data_i[31:8], 8'h80};
            default: pad_word = data_i;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        ld_word = 32'h0;
        case (state)
            S_PASS: begin
                load    = accept;
                ld_word = (last_i && last_bytes_i < 3'd4) ? pad_word : data_i;
            end
            S_PAD: begin
                load    = out_free;
                ld_word = pad_pend ? 32'h8000_0000 : 32'h0;
            end
            S_LEN_HI: begin
                load    = out_free;
                ld_word = len_bits[63:32];
            end
            default: begin
                load    = out_free && !lo_loaded;
                ld_word = len_bits[31:0];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_PASS;
            widx         <= 4'd0;
            bcnt         <= '0;
            pad_pend     <= 1'b0;
            lo_loaded    <= 1'b0;
            run          <= 1'b0;
            word_o       <= 32'h0;
            word_valid_o <= 1'b0;
            block_last_o <= 1'b0;
            msg_last_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            run <= 1'b1;
            if (out_free) begin
                word_valid_o <= load;
                word_o       <= load ? ld_word : 32'h0;
                block_last_o <= load && (widx == 4'd15);
                msg_last_o   <= load && (state == S_LEN_LO);
            end
            if (load) widx <= widx_nxt;

            case (state)
                S_PASS: begin
                    if (accept) begin
                        busy_o <= 1'b1;
                        bcnt   <= bcnt + bcnt_inc;
                        if (last_i) begin
                            pad_pend <= (last_bytes_i == 3'd4);
                            // 0x80 already placed and the next slot is 14: length goes right here.
                            state    <= (last_bytes_i != 3'd4 && widx_nxt == 4'd14) ? S_LEN_HI : S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (load) begin
                        pad_pend <= 1'b0;
                        if (widx_nxt == 4'd14) state <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (load) state <= S_LEN_LO;
                end
                default: begin
                    if (load) begin
                        lo_loaded <= 1'b1;
                    end else if (lo_loaded && word_valid_o && word_ready_i) begin
                        state     <= S_PASS;
                        lo_loaded <= 1'b0;
                        busy_o    <= 1'b0;
                        bcnt      <= '0;
                        widx      <= 4'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Bench for sha1_msg_padder: byte-level padding model feeds a scoreboard; monitor compares
// every output transfer, checks stall stability and ready/busy behaviour during the tail.
module tb_sha1_msg_padder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_i = 32'h0;
    logic        valid_i = 1'b0;
    logic        last_i = 1'b0;
    logic [2:0]  last_bytes_i = 3'd0;
    logic        ready_o;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i = 1'b1;
    logic        block_last_o;
    logic        msg_last_o;
    logic        busy_o;

    typedef struct packed {
        logic [31:0] w;
        logic        bl;
        logic        ml;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          bp_en = 1'b0;
    int          msgs_sent = 0;
    int          msgs_done = 0;
    bit          hold_v = 1'b0;
    logic [33:0] hold;

    sha1_msg_padder #(.BCNT_W(32)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
        .last_bytes_i(last_bytes_i), .ready_o(ready_o), .word_o(word_o),
        .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
        .block_last_o(block_last_o), .msg_last_o(msg_last_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (valid_i && last_i)
            assert (last_bytes_i <= 3'd4) else $error("last_bytes_i out of range: %0d", last_bytes_i);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: pad the byte string as the hash standard describes, then cut into words.
    function automatic void ref_model(input byte unsigned m[$]);
        byte unsigned    p[$];
        longint unsigned len_bits;
        int              nw;
        exp_t            e;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        len_bits = 64'(m.size()) * 8;
        for (int i = 7; i >= 0; i--) p.push_back(8'(len_bits >> (8 * i)));
        nw = p.size() / 4;
        for (int i = 0; i < nw; i++) begin
            e.w  = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
            e.bl = (i % 16 == 15);
            e.ml = (i == nw - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic drive_word(input logic [31:0] w, input bit last, input logic [2:0] k);
        int t;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        valid_i = 1'b1; data_i = w; last_i = last; last_bytes_i = k;
        t = 0;
        @(negedge clk);
        while (!ready_o && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0; last_i = 1'b0;
        data_i = $urandom; last_bytes_i = 3'($urandom_range(0, 4));
        if (last) msgs_sent++;
    endtask

    task automatic send_msg(input byte unsigned m[$], input bit extra_k0, input bit check);
        int          n;
        int          k;
        logic [31:0] w;
        bit          last;
        n = m.size();
        if (check) ref_model(m);
        for (int i = 0; i < n; i += 4) begin
            k = (n - i >= 4) ? 4 : n - i;
            for (int j = 0; j < 4; j++)
                w[31-8*j -: 8] = (j < k) ? m[i+j] : 8'($urandom);
            last = (i + 4 >= n) && !extra_k0;
            drive_word(w, last, last ? 3'(k) : 3'($urandom_range(0, 4)));
        end
        if (n == 0 || extra_k0) drive_word($urandom, 1'b1, 3'd0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        chk("busy_idle", busy_o, 0);
        chk("valid_idle", word_valid_o, 0);
    endtask

    initial begin : bp_proc
        forever begin
            @(posedge clk);
            #1;
            word_ready_i = bp_en ? ($urandom_range(0, 99) < 55) : 1'b1;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rst) begin
                if (msgs_sent != msgs_done) begin
                    chk("ready_in_tail", ready_o, 0);
                    chk("busy_in_tail", busy_o, 1);
                end
                if (hold_v && word_valid_o)
                    chk("stall_stable", {word_o, block_last_o, msg_last_o}, hold);
                hold_v = word_valid_o && !word_ready_i;
                hold   = {word_o, block_last_o, msg_last_o};
                if (word_valid_o && word_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {word_o, block_last_o, msg_last_o}, 64'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", word_o, e.w);
                        chk("block_last", block_last_o, e.bl);
                        chk("msg_last", msg_last_o, e.ml);
                        if (msg_last_o) msgs_done++;
                    end
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        byte unsigned m[$];
        int           len;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {ready_o, word_valid_o, word_o, block_last_o, msg_last_o, busy_o}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("ready_after_rst", ready_o, 1);

        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0, 1'b1); wait_drain();

        m.delete();
        send_msg(m, 1'b0, 1'b1); wait_drain();

        m.delete();
        for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
        send_msg(m, 1'b0, 1'b1); wait_drain();

        m.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'h31 + 8'(i % 4));
        send_msg(m, 1'b0, 1'b1); wait_drain();

        bp_en = 1'b1;
        m.delete();
        for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
        send_msg(m, 1'b0, 1'b1); wait_drain();

        // Abort a message after 5 words; its output is not scoreboarded.
        mon_en = 1'b0;
        m.delete();
        for (int i = 0; i < 40; i++) m.push_back(8'($urandom));
        for (int i = 0; i < 5; i++) drive_word({m[4*i], m[4*i+1], m[4*i+2], m[4*i+3]}, 1'b0, 3'd0);
        chk("busy_mid_msg", busy_o, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_async", {ready_o, word_valid_o, word_o, block_last_o, msg_last_o, busy_o}, 0);
        @(posedge clk);
        #1;
        chk("rst_mid_edge", {ready_o, word_valid_o, word_o, block_last_o, msg_last_o, busy_o}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0, 1'b1); wait_drain();

        for (int r = 0; r < 30; r++) begin
            bp_en = ($urandom_range(0, 1) == 1);
            len = (r < 8) ? 52 + r : $urandom_range(0, 150);
            m.delete();
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            send_msg(m, (len % 4 == 0) && (len > 0) && ($urandom_range(0, 1) == 1), 1'b1);
            if ($urandom_range(0, 2) == 0) wait_drain();
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
